// File: rtl/traffic_light_multi.sv
// N-direction round-robin intersection controller.
// Green/yellow/all-red per approach, early pass with minimum green, latched walk phase.
module traffic_light_multi #(
    parameter int N_DIR       = 2,
    parameter int CNT_W       = 8,
    parameter int T_GREEN     = 8,
    parameter int T_MIN_GREEN = 3,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 4,
    localparam int DIR_W      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pass,
    input  logic             ped_req,
    output logic [N_DIR-1:0] R,
    output logic [N_DIR-1:0] G,
    output logic [N_DIR-1:0] Y,
    output logic             walk,
    output logic [DIR_W-1:0] phase_dir
);

    if (N_DIR < 2) begin : g_chk_ndir
        $error("N_DIR must be >= 2");
    end
    if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 ||
        T_WALK < 1 || T_MIN_GREEN < 1) begin : g_chk_min
        $error("phase durations must be >= 1");
    end
    if (T_GREEN > 2**CNT_W || T_YELLOW > 2**CNT_W ||
        T_ALLRED > 2**CNT_W || T_WALK > 2**CNT_W ||
        T_MIN_GREEN > 2**CNT_W) begin : g_chk_max
        $error("phase durations must fit in CNT_W");
    end
    if (T_MIN_GREEN > T_GREEN) begin : g_chk_mg
        $error("T_MIN_GREEN must not exceed T_GREEN");
    end

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_WALK
    } state_t;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(T_WALK - 1);
    localparam logic [DIR_W-1:0] DIR_MAX  = DIR_W'(N_DIR - 1);

    state_t           st, st_n;
    logic [DIR_W-1:0] dir, dir_n, dir_inc;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pass_pend, pass_pend_n;
    logic             ped_pend, ped_pend_n;

    assign dir_inc = (dir == DIR_MAX) ? '0 : dir + 1'b1;

    always_comb begin
        st_n        = st;
        dir_n       = dir;
        cnt_n       = cnt + 1'b1;
        pass_pend_n = pass_pend;
        ped_pend_n  = ped_pend | ped_req;
        unique case (st)
            S_GREEN: begin
                if (cnt == G_LAST ||
                    ((pass || pass_pend) && cnt >= MIN_LAST)) begin
                    st_n        = S_YELLOW;
                    cnt_n       = '0;
                    pass_pend_n = 1'b0;
                end else if (pass) begin
                    // too early to end green: remember the request
                    pass_pend_n = 1'b1;
                end
            end
            S_YELLOW: begin
                if (cnt == Y_LAST) begin
                    st_n  = S_ALLRED;
                    cnt_n = '0;
                end
            end
            S_ALLRED: begin
                if (cnt == A_LAST) begin
                    cnt_n = '0;
                    if (ped_pend) begin
                        st_n       = S_WALK;
                        ped_pend_n = 1'b0;
                    end else begin
                        st_n  = S_GREEN;
                        dir_n = dir_inc;
                    end
                end
            end
            S_WALK: begin
                if (cnt == W_LAST) begin
                    st_n  = S_GREEN;
                    cnt_n = '0;
                    dir_n = dir_inc;
                end
            end
            default: begin
                st_n  = S_GREEN;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_GREEN;
            dir       <= '0;
            cnt       <= '0;
            pass_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else begin
            st        <= st_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
            pass_pend <= pass_pend_n;
            ped_pend  <= ped_pend_n;
        end
    end

    logic [N_DIR-1:0] sel;
    assign sel = N_DIR'(1) << dir;

    always_comb begin
        G = '0;
        Y = '0;
        if (st == S_GREEN) G = sel;
        if (st == S_YELLOW) Y = sel;
    end

    assign R         = ~(G | Y);
    assign walk      = (st == S_WALK);
    assign phase_dir = dir;

endmodule
